riscv_timer: RTL
================

Name: riscv_timer

Overview:
Memory-mapped 32-bit timer/compare peripheral on the data bus, decoded as bus slave 3 next to the gpio and uart slaves. Its irq output drives bit 0 of the core's external interrupt vector. A prescaled counter runs up to a compare value, latches a sticky pending flag on match, and then either reloads (periodic mode) or stops (one-shot mode). It uses the same sel/enable/write/addr/wdata/rdata slave handshake as the other peripherals.

Parameters:
XLEN, 32, bus address/data width; counter and compare registers are XLEN wide
PRESC_W, 16, width of the prescaler register and the prescaler counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sel  input  1  slave select from the bus controller
enable  input  1  data request strobe from the core
write  input  1  1 = write access, 0 = read access
addr  input  XLEN  byte address; only addr[4:2] is decoded
wdata  input  XLEN  write data; full-word writes only, byte enables ignored
rdata  output  XLEN  registered read data
irq  output  1  interrupt request, level, active-high

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state is updated on posedge clk.
- Access strobes: access = sel & enable; wr = access & write; rd = access & ~write.
- Register map (addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQEN; other bits read 0.
  - 1 PRESC: [PRESC_W-1:0].
  - 2 CNT: read/write.
  - 3 CMP: read/write.
  - 4 STATUS: bit0 PEND, write 1 to clear; bit1 RUN = EN, read-only.
  - 5-7: read 0, writes ignored.
- Reset values: CTRL=0, PRESC=0, CNT=0, CMP=0, PEND=0, prescaler counter pc=0, rdata=0, irq=0.
- Read latency is 1 cycle: rdata <= selected register on a rd cycle. rdata holds its previous value when there is no rd. No wait states.
- Write takes effect on the clock edge of the wr cycle. A read in the cycle after a write returns the new value.
- Prescaler:
  - While EN=1, pc counts 0..PRESC and wraps to 0.
  - tick = EN & (pc == PRESC). PRESC=0 gives a tick every cycle.
  - While EN=0, pc holds at 0.
  - A write to PRESC, or to CTRL with EN=1, clears pc to 0.
- On tick:
  - If CNT == CMP: set PEND and CNT <= 0. If PERIODIC=0, also clear EN (one-shot stop).
  - Otherwise CNT <= CNT + 1, mod 2^XLEN. Wrap from all-ones to 0 raises no event.
- irq = PEND & IRQEN, combinational from registers. It stays asserted until PEND is cleared or IRQEN is cleared.
- Simultaneous events:
  - SW write to CNT and a tick in the same cycle: the SW write wins and no match is evaluated that cycle.
  - SW write to CTRL and a one-shot auto-clear of EN in the same cycle: the SW write wins.
  - STATUS write with bit0=1 and a match in the same cycle: set wins, PEND stays 1.
  - Writing CMP below the current CNT: no match until CNT wraps through 2^XLEN.
- Reset mid-operation: every register returns to its reset value at the next edge, irq drops, any in-flight read returns 0 on the following cycle.
- Unselected bus traffic (sel=0) changes no state.

Test Plan:
- Reset, then read each of offsets 0x00-0x1C -> rdata=0 one cycle after each request. irq=0.
- PRESC=3, CMP=4, CTRL=0b111 (periodic, irq en) -> CNT increments every 4 clk. PEND and irq assert 20 clk after the CTRL write, then again every 20 clk. CNT reads 0 right after each match.
- PRESC=0, CMP=2, CTRL=0b101 (one-shot) -> match after 3 ticks. EN reads 0, STATUS reads 0b01, CNT holds 0. irq stays high until STATUS is written with 0x1, then irq=0 the next cycle.
- Periodic with PRESC=0, CMP=5: write CNT=100 in the same cycle a tick occurs -> CNT reads 100, not 1. Counting then continues from 100, 101, ...
- PRESC=0, CMP=0, periodic: issue STATUS W1C on a cycle where a match also fires -> PEND remains 1 and irq remains 1.
- Assert rst for 1 cycle while running with PEND=1 -> next cycle irq=0, and CTRL, CNT and STATUS all read 0.

Source files
------------

// File: rtl/riscv_timer.sv
// Memory-mapped prescaled timer/compare slave with a sticky match flag and a level interrupt.
// Counts up to CMP on each prescaler tick, then reloads (periodic) or stops (one-shot).
module riscv_timer #(
    parameter int XLEN    = 32,
    parameter int PRESC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel,
    input  logic            enable,
    input  logic            write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            irq
);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PRESC  = 3'd1;
    localparam logic [2:0] REG_CNT    = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    logic               access;
    logic               wr;
    logic               rd;
    logic [2:0]         reg_idx;

    logic               ctrl_en;
    logic               ctrl_periodic;
    logic               ctrl_irqen;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pc;
    logic [XLEN-1:0]    cnt;
    logic [XLEN-1:0]    cmp;
    logic               pend;

    logic               wr_ctrl;
    logic               wr_presc;
    logic               wr_cnt;
    logic               wr_cmp;
    logic               wr_status;
    logic               tick;
    logic               match;
    logic [XLEN-1:0]    read_val;
    logic               unused_addr_bits;

    assign access  = sel & enable;
    assign wr      = access & write;
    assign rd      = access & ~write;
    assign reg_idx = addr[4:2];

    assign wr_ctrl   = wr & (reg_idx == REG_CTRL);
    assign wr_presc  = wr & (reg_idx == REG_PRESC);
    assign wr_cnt    = wr & (reg_idx == REG_CNT);
    assign wr_cmp    = wr & (reg_idx == REG_CMP);
    assign wr_status = wr & (reg_idx == REG_STATUS);

    assign unused_addr_bits = ^{addr[XLEN-1:5], addr[1:0]};

    // A software write to CNT overrides the tick, so no compare is evaluated in that cycle.
    assign tick  = ctrl_en & (pc == presc);
    assign match = tick & ~wr_cnt & (cnt == cmp);

    assign irq = pend & ctrl_irqen;

    always_comb begin
        read_val = '0;
        case (reg_idx)
            REG_CTRL:   read_val[2:0]         = {ctrl_irqen, ctrl_periodic, ctrl_en};
            REG_PRESC:  read_val[PRESC_W-1:0] = presc;
            REG_CNT:    read_val              = cnt;
            REG_CMP:    read_val              = cmp;
            REG_STATUS: read_val[1:0]         = {ctrl_en, pend};
            default:    read_val              = '0;
        endcase
    end

    // Any CTRL write restarts the prescaler so a fresh enable always begins a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (wr_presc || wr_ctrl || !ctrl_en || tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_irqen    <= 1'b0;
            presc         <= '0;
            cnt           <= '0;
            cmp           <= '0;
            pend          <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en       <= wdata[0];
                ctrl_periodic <= wdata[1];
                ctrl_irqen    <= wdata[2];
            end else if (match && !ctrl_periodic) begin
                ctrl_en <= 1'b0;
            end

            if (wr_presc) begin
                presc <= wdata[PRESC_W-1:0];
            end

            if (wr_cmp) begin
                cmp <= wdata;
            end

            if (wr_cnt) begin
                cnt <= wdata;
            end else if (match) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + XLEN'(1);
            end

            // A match in the same cycle as a clear keeps the flag set.
            if (match) begin
                pend <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= read_val;
        end
    end

endmodule
